// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 36
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_read_data,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_write_enable, mem_addr, mem_write_data
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_read_data,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_write_enable, mem_addr, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin (or fixed-priority) arbiter sequencing one memory access per cycle
// into a single-port memory with combinational read; read data returns registered.
module mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 36,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic              clk,
    input logic              reset_n,
    mem_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_P0 = 2'd1, SEL_P1 = 2'd2} sel_e;

    sel_e              sel_s;
    logic              elig0_s;
    logic              elig1_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    logic              gnt0_r;
    logic              gnt1_r;
    logic              rvalid0_r;
    logic              rvalid1_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              acc_valid_r;
    logic              acc_port_r;
    logic              last_grant_r;

    // Eligibility excludes a port in its grant cycle so one request is never granted twice.
    always_comb begin
        sel_s       = SEL_NONE;
        win_we_s    = 1'b0;
        win_addr_s  = bus.p0_addr;
        win_wdata_s = bus.p0_wdata;
        elig0_s     = bus.p0_req & ~gnt0_r;
        elig1_s     = bus.p1_req & ~gnt1_r;
        case ({elig1_s, elig0_s})
            2'b01:   sel_s = SEL_P0;
            2'b10:   sel_s = SEL_P1;
            2'b11: begin
                if (FIXED_PRIO || last_grant_r) begin
                    sel_s = SEL_P0;
                end else begin
                    sel_s = SEL_P1;
                end
            end
            default: sel_s = SEL_NONE;
        endcase
        case (sel_s)
            SEL_P0: begin
                win_we_s    = bus.p0_we;
                win_addr_s  = bus.p0_addr;
                win_wdata_s = bus.p0_wdata;
            end
            SEL_P1: begin
                win_we_s    = bus.p1_we;
                win_addr_s  = bus.p1_addr;
                win_wdata_s = bus.p1_wdata;
            end
            default: begin
                win_we_s    = 1'b0;
                win_addr_s  = addr_r;
                win_wdata_s = wdata_r;
            end
        endcase
    end

    // Arbitration state, latched access and read-return registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt0_r       <= 1'b0;
            gnt1_r       <= 1'b0;
            rvalid0_r    <= 1'b0;
            rvalid1_r    <= 1'b0;
            rdata0_r     <= {DATA_W{1'b0}};
            rdata1_r     <= {DATA_W{1'b0}};
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            acc_valid_r  <= 1'b0;
            acc_port_r   <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            rvalid0_r <= acc_valid_r & ~we_r & ~acc_port_r;
            rvalid1_r <= acc_valid_r & ~we_r &  acc_port_r;
            if (acc_valid_r && !we_r && !acc_port_r) begin
                rdata0_r <= bus.mem_read_data;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (acc_valid_r && !we_r && acc_port_r) begin
                rdata1_r <= bus.mem_read_data;
            end else begin
                rdata1_r <= rdata1_r;
            end
            // Address and data hold through idle cycles; only the write enable drops.
            addr_r  <= win_addr_s;
            wdata_r <= win_wdata_s;
            we_r    <= win_we_s;
            case (sel_s)
                SEL_P0: begin
                    gnt0_r       <= 1'b1;
                    gnt1_r       <= 1'b0;
                    acc_valid_r  <= 1'b1;
                    acc_port_r   <= 1'b0;
                    last_grant_r <= 1'b0;
                end
                SEL_P1: begin
                    gnt0_r       <= 1'b0;
                    gnt1_r       <= 1'b1;
                    acc_valid_r  <= 1'b1;
                    acc_port_r   <= 1'b1;
                    last_grant_r <= 1'b1;
                end
                default: begin
                    gnt0_r       <= 1'b0;
                    gnt1_r       <= 1'b0;
                    acc_valid_r  <= 1'b0;
                    acc_port_r   <= acc_port_r;
                    last_grant_r <= last_grant_r;
                end
            endcase
        end
    end

    assign bus.p0_gnt           = gnt0_r;
    assign bus.p1_gnt           = gnt1_r;
    assign bus.p0_rvalid        = rvalid0_r;
    assign bus.p1_rvalid        = rvalid1_r;
    assign bus.p0_rdata         = rdata0_r;
    assign bus.p1_rdata         = rdata1_r;
    assign bus.mem_write_enable = we_r;
    assign bus.mem_addr         = addr_r;
    assign bus.mem_write_data   = wdata_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical requests and
// compares both against a per-edge behavioural model with its own memory image.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 36;

    logic clk = 1'b0;
    logic rst_n;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fp ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .reset_n(rst_n), .bus(bus_rr));
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset_n(rst_n), .bus(bus_fp));

    always #5 clk = ~clk;

    assign bus_rr.p0_req = req[0];   assign bus_fp.p0_req = req[0];
    assign bus_rr.p0_we = we[0];     assign bus_fp.p0_we = we[0];
    assign bus_rr.p0_addr = addr[0]; assign bus_fp.p0_addr = addr[0];
    assign bus_rr.p0_wdata = wdata[0]; assign bus_fp.p0_wdata = wdata[0];
    assign bus_rr.p1_req = req[1];   assign bus_fp.p1_req = req[1];
    assign bus_rr.p1_we = we[1];     assign bus_fp.p1_we = we[1];
    assign bus_rr.p1_addr = addr[1]; assign bus_fp.p1_addr = addr[1];
    assign bus_rr.p1_wdata = wdata[1]; assign bus_fp.p1_wdata = wdata[1];

    // Single-port memories: combinational read, write on the rising edge.
    logic [DW-1:0] mem_rr [4096];
    logic [DW-1:0] mem_fp [4096];
    assign bus_rr.mem_read_data = mem_rr[bus_rr.mem_addr];
    assign bus_fp.mem_read_data = mem_fp[bus_fp.mem_addr];
    always @(posedge clk) if (bus_rr.mem_write_enable === 1'b1) mem_rr[bus_rr.mem_addr] <= bus_rr.mem_write_data;
    always @(posedge clk) if (bus_fp.mem_write_enable === 1'b1) mem_fp[bus_fp.mem_addr] <= bus_fp.mem_write_data;

    // Observed outputs gathered per instance (0 = round-robin, 1 = fixed priority).
    logic [4:0]    o_ctl  [2];
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_wd   [2];
    logic [DW-1:0] o_rd0  [2];
    logic [DW-1:0] o_rd1  [2];
    assign o_ctl[0] = {bus_rr.p0_gnt, bus_rr.p1_gnt, bus_rr.p0_rvalid, bus_rr.p1_rvalid, bus_rr.mem_write_enable};
    assign o_ctl[1] = {bus_fp.p0_gnt, bus_fp.p1_gnt, bus_fp.p0_rvalid, bus_fp.p1_rvalid, bus_fp.mem_write_enable};
    assign o_addr[0] = bus_rr.mem_addr;       assign o_addr[1] = bus_fp.mem_addr;
    assign o_wd[0]   = bus_rr.mem_write_data; assign o_wd[1]   = bus_fp.mem_write_data;
    assign o_rd0[0]  = bus_rr.p0_rdata;       assign o_rd0[1]  = bus_fp.p0_rdata;
    assign o_rd1[0]  = bus_rr.p1_rdata;       assign o_rd1[1]  = bus_fp.p1_rdata;

    // Reference model state.
    logic [DW-1:0] ref_mem [2][4096];
    logic [1:0]    m_gnt    [2];
    logic [1:0]    m_rvalid [2];
    logic [DW-1:0] m_rdata  [2][2];
    logic          m_acc    [2];
    logic          m_we     [2];
    int            m_port   [2];
    int            m_last   [2];
    logic [AW-1:0] m_addr   [2];
    logic [DW-1:0] m_wdata  [2];

    int n_checks = 0;
    int n_pass   = 0;
    string nm [2] = '{"rr", "fp"};
    logic [AW-1:0] pool [8] = '{12'h810, 12'h010, 12'h020, 12'h000, 12'hFFF, 12'h123, 12'h7FF, 12'h800};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One rising edge of the model for instance i, from the inputs present at that edge.
    task automatic model_edge(input int i);
        logic e0, e1;
        int   w;
        m_rvalid[i] = 2'b00;
        if (m_acc[i]) begin
            if (m_we[i]) begin
                ref_mem[i][m_addr[i]] = m_wdata[i];
            end else if (rst_n) begin
                m_rvalid[i][m_port[i]] = 1'b1;
                m_rdata[i][m_port[i]]  = ref_mem[i][m_addr[i]];
            end
        end
        if (!rst_n) begin
            m_gnt[i] = 2'b00; m_acc[i] = 1'b0; m_we[i] = 1'b0; m_last[i] = 1; m_port[i] = 0;
            m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i][0] = '0; m_rdata[i][1] = '0;
            return;
        end
        e0 = req[0] && !m_gnt[i][0];
        e1 = req[1] && !m_gnt[i][1];
        if (e0 && e1) w = (i == 1) ? 0 : 1 - m_last[i];
        else if (e0)  w = 0;
        else if (e1)  w = 1;
        else          w = -1;
        m_gnt[i] = 2'b00;
        m_acc[i] = (w >= 0);
        if (w >= 0) begin
            m_gnt[i][w] = 1'b1;
            m_last[i]   = w;
            m_port[i]   = w;
            m_addr[i]   = addr[w];
            m_wdata[i]  = wdata[w];
            m_we[i]     = we[w];
        end else begin
            m_we[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq({nm[i], "_ctl"}, 64'(o_ctl[i]),
                     64'({m_gnt[i][0], m_gnt[i][1], m_rvalid[i][0], m_rvalid[i][1], m_acc[i] & m_we[i]}));
            check_eq({nm[i], "_mem_addr"}, 64'(o_addr[i]), 64'(m_addr[i]));
            check_eq({nm[i], "_mem_wdata"}, 64'(o_wd[i]), 64'(m_wdata[i]));
            check_eq({nm[i], "_p0_rdata"}, 64'(o_rd0[i]), 64'(m_rdata[i][0]));
            check_eq({nm[i], "_p1_rdata"}, 64'(o_rd1[i]), 64'(m_rdata[i][1]));
        end
    endtask

    task automatic set_port(input int n, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[n] = r; we[n] = w; addr[n] = a; wdata[n] = d;
    endtask

    // Single-port access: request, wait (bounded) for the grant, then release.
    task automatic do_access(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 1'b0;
        set_port(n, 1'b1, w, a, d);
        for (int k = 0; k < 4 && !got; k++) begin
            step();
            got = m_gnt[0][n];
        end
        if (!got) check_eq("access_grant_timeout", 64'd0, 64'd1);
        req[n] = 1'b0;
        step();
    endtask

    initial begin
        int cnt0, cnt1;
        logic [DW-1:0] v;
        for (int i = 0; i < 2; i++) begin
            m_gnt[i] = 2'b00; m_rvalid[i] = 2'b00; m_acc[i] = 1'b0; m_we[i] = 1'b0;
            m_port[i] = 0; m_last[i] = 1; m_addr[i] = '0; m_wdata[i] = '0;
            m_rdata[i][0] = '0; m_rdata[i][1] = '0;
        end
        rst_n = 1'b0;
        set_port(0, 1'b1, 1'b0, 12'h100, 36'h0);
        set_port(1, 1'b1, 1'b0, 12'h200, 36'h0);
        for (int k = 0; k < 3; k++) step();
        check_eq("reset_quiet", 64'(o_ctl[0]), 64'd0);
        rst_n = 1'b1;
        step();
        check_eq("first_tie_p0", 64'(o_ctl[0][4:3]), 64'(2'b10));
        check_eq("first_tie_p0_fp", 64'(o_ctl[1][4:3]), 64'(2'b10));
        req[0] = 1'b0; req[1] = 1'b0;
        step(); step();

        // Preload the address pool through ordinary writes.
        for (int k = 0; k < 8; k++) begin
            v = (pool[k] == 12'h810) ? 36'h123456789 : 36'({$urandom(), $urandom()});
            do_access(k % 2, 1'b1, pool[k], v);
        end

        // Single read on port 0.
        set_port(0, 1'b1, 1'b0, 12'h810, 36'h0);
        step();
        check_eq("rd_gnt", 64'(o_ctl[0]), 64'(5'b10000));
        req[0] = 1'b0;
        step();
        check_eq("rd_rvalid", 64'(o_ctl[0]), 64'(5'b00100));
        check_eq("rd_data", 64'(o_rd0[0]), 64'(36'h123456789));

        // Port 1 write then read of the same address.
        set_port(1, 1'b1, 1'b1, 12'h010, 36'hABCDEF012);
        step();
        check_eq("wr_access", 64'(o_ctl[0]), 64'(5'b01001));
        set_port(1, 1'b1, 1'b0, 12'h010, 36'h0);
        step();
        step();
        req[1] = 1'b0;
        step();
        check_eq("wr_rd_data", 64'(o_rd1[0]), 64'(36'hABCDEF012));
        step();

        // Continuous contention for 8 cycles.
        set_port(0, 1'b1, 1'b0, 12'h000, 36'h0);
        set_port(1, 1'b1, 1'b0, 12'hFFF, 36'h0);
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            cnt0 += int'(o_ctl[0][4]);
            cnt1 += int'(o_ctl[0][3]);
        end
        check_eq("rr_p0_grants", 64'(cnt0), 64'd4);
        check_eq("rr_p1_grants", 64'(cnt1), 64'd4);
        req[0] = 1'b0; req[1] = 1'b0;
        step(); step();

        // Reset asserted during a port 0 write access.
        set_port(0, 1'b1, 1'b1, 12'h020, 36'h0DEADBEEF);
        step();
        check_eq("rst_wr_gnt", 64'(o_ctl[0]), 64'(5'b10001));
        rst_n = 1'b0; req[0] = 1'b0;
        step();
        check_eq("rst_wr_mem_rr", 64'(mem_rr[12'h020]), 64'(36'h0DEADBEEF));
        check_eq("rst_wr_mem_fp", 64'(mem_fp[12'h020]), 64'(36'h0DEADBEEF));
        rst_n = 1'b1;
        step();
        check_eq("rst_no_grant", 64'(o_ctl[0]), 64'd0);
        do_access(0, 1'b0, 12'h020, 36'h0);

        // Randomized traffic obeying the requester hold rule for both instances.
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int n = 0; n < 2; n++) begin
                if (req[n] && (!m_gnt[0][n] || !m_gnt[1][n])) begin
                    if ($urandom_range(0, 3) == 0) req[n] = 1'b0;
                end else begin
                    req[n]   = ($urandom_range(0, 3) != 0);
                    we[n]    = 1'($urandom_range(0, 1));
                    addr[n]  = pool[$urandom_range(0, 7)];
                    wdata[n] = 36'({$urandom(), $urandom()});
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port 4096 x 36 unified memory.
- The memory has a combinational read and a write on the rising clock edge.
- Shares the memory between the instruction-fetch requester (port 0) and the load/store requester (port 1).
- Registers each accepted request, drives one memory access per cycle and returns registered read data with a valid pulse.

Parameters:
- ADDR_W, 12: memory address width.
- DATA_W, 36: memory word width.
- FIXED_PRIO, 0: 0 selects round-robin; 1 makes port 0 always win a tie.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- p0_req  in  1  port 0 access request; held until p0_gnt is seen.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 grant, one-cycle pulse.
- p0_rvalid  out  1  port 0 read data valid, one-cycle pulse.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_write_enable  out  1  to memory write_enable.
- mem_addr  out  ADDR_W  to memory addr.
- mem_write_data  out  DATA_W  to memory write_data.
- mem_read_data  in  DATA_W  from memory read_data (combinational in addr).

Behaviour:
- Reset (reset_n low at an edge) clears:
  - p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_write_enable → 0.
  - p0_rdata, p1_rdata, mem_addr, mem_write_data → 0.
  - Internal access-valid flag → 0; last_grant → 1, so port 0 wins the first tie.
- Eligibility: port N is eligible at an edge if pN_req=1 and pN_gnt=0 at that edge. A request is consumed by its grant cycle and is never granted twice.
- Arbitration (at each edge, reset_n high):
  - Neither port eligible: no grant; access-valid ← 0.
  - One port eligible: grant that port.
  - Both eligible, FIXED_PRIO=0: grant the port not equal to last_grant.
  - Both eligible, FIXED_PRIO=1: grant port 0.
  - On a grant:
    - pN_gnt ← 1 (the other gnt ← 0).
    - last_grant ← N.
    - Latch pN_addr → mem_addr, pN_wdata → mem_write_data, pN_we → mem_write_enable.
    - access-valid ← 1; the winning port ID is latched.
- Access cycle = the cycle in which gnt is high. The memory sees the latched address, data and write enable for exactly that cycle.
  - Write: the memory commits at the edge ending the access cycle.
  - Read: at that edge, pN_rdata ← mem_read_data and pN_rvalid ← 1 for one cycle.
- Latency: req high before edge E → gnt high in cycle E..E+1 → for reads, rvalid/rdata valid in cycle E+1..E+2. Writes produce no rvalid.
- Throughput: one access per cycle overall. A single port alone gets at most one grant every two cycles; alternating ports sustain one per cycle.
- pN_rdata holds its value until the next read completion for port N.
- No access cycle: mem_write_enable=0. mem_addr and mem_write_data hold their last values.
- Write then read of the same address (consecutive grants): the read returns the newly written data.
- Requester rule: pN_we, pN_addr and pN_wdata must be stable while pN_req is high and pN_gnt is low. Deasserting req before a grant withdraws the request.
- Reset mid-operation:
  - The memory is not reset. If reset_n goes low during an access cycle, that access still completes at the edge (write commits) and all outputs are then cleared.
  - No rvalid is produced for a read in progress at reset.
  - Pending un-granted requests are dropped.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with both reqs high → all gnt, rvalid and mem_write_enable 0; first edge after release grants port 0.
- Single read: p0 reads addr 0x810 with mem[0x810]=36'h123456789 → p0_gnt 1 cycle after req, p0_rvalid next cycle, p0_rdata=36'h123456789; p1 outputs quiet.
- Write then read: p1 writes 36'hABCDEF012 to 0x010, then reads 0x010 → one write access, then p1_rdata=36'hABCDEF012.
- Contention, round-robin: both ports request continuously for 8 cycles → grants strictly alternate 0,1,0,1…; each port gets 4 grants; mem_addr alternates accordingly.
- Contention, FIXED_PRIO=1: both request continuously → port 0 granted every other cycle; port 1 gets only the cycles where port 0 is ineligible.
- Reset during a write access: reset_n=0 in p0 write grant cycle to 0x020 → memory holds the new value; no rvalid; next grant only after release.
